// File: rtl/interface_sender.sv
// Transmit-side valid/ready register slice with a main/skid buffer and a
// saturating back-pressure counter for debug.
module interface_sender #(
   parameter int DATA_WIDTH      = 32,
   parameter int STALL_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid_in,
   input  logic [DATA_WIDTH-1:0]      data_in,
   output logic                       ready_out,
   output logic                       valid_out,
   output logic [DATA_WIDTH-1:0]      data_out,
   input  logic                       ready_in,
   output logic [STALL_CNT_WIDTH-1:0] stall_cnt,
   input  logic                       clr_stall,
   output logic [1:0]                 o_dbg_state
);

   // Handshake semantics: a beat moves on a rising edge where valid and ready
   // are both high; valid never depends on ready, and once raised valid/data
   // hold until that transfer edge.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_next_state;
   logic [DATA_WIDTH-1:0]      r_main;
   logic [DATA_WIDTH-1:0]      r_skid;
   logic [DATA_WIDTH-1:0]      w_next_main;
   logic [DATA_WIDTH-1:0]      w_next_skid;
   logic [STALL_CNT_WIDTH-1:0] r_stall;
   logic                       w_push;
   logic                       w_pop;

   // Every output is a pure decode of flops, so no input reaches an output.
   assign valid_out   = (r_state != EMPTY);
   assign ready_out   = (r_state != FULL);
   assign data_out    = r_main;
   assign stall_cnt   = r_stall;
   assign o_dbg_state = r_state;

   assign w_push = valid_in && ready_out;
   assign w_pop  = valid_out && ready_in;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_next_state;
         r_main  <= w_next_main;
         r_skid  <= w_next_skid;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_main  = r_main;
      w_next_skid  = r_skid;
      case (r_state)
         EMPTY: begin
            if (w_push) begin
               w_next_main  = data_in;
               w_next_state = ONE;
            end
         end
         ONE: begin
            if (w_push && w_pop) begin
               w_next_main = data_in;
            end else if (w_push) begin
               w_next_skid  = data_in;
               w_next_state = FULL;
            end else if (w_pop) begin
               w_next_state = EMPTY;
            end
         end
         FULL: begin
            // ready_out is low here, so only the pop can happen.
            if (w_pop) begin
               w_next_main  = r_skid;
               w_next_state = ONE;
            end
         end
         default: begin
            w_next_state = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall <= '0;
      end else if (clr_stall) begin
         r_stall <= '0;
      end else if (valid_out && !ready_in && (r_stall != '1)) begin
         r_stall <= r_stall + 1'b1;
      end
   end

endmodule

// File: doc/interface_sender.md
# interface_sender

Transmit-side register slice for the cache valid/ready stage interfaces. It accepts a data beat from an upstream producer and drives it to a downstream consumer with fully registered `valid_out`, `data_out` and `ready_out`. A two-entry main/skid buffer sustains one beat per cycle while the consumer toggles ready. It sits at the output of a producing stage, feeding the receive-side interface controller of the next stage, and keeps a saturating count of back-pressure cycles for debug.

## Interface
- `DATA_WIDTH`, 32, width of the data beat
- `STALL_CNT_WIDTH`, 16, width of the back-pressure counter
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `valid_in`  in  1  upstream beat valid
- `data_in`  in  DATA_WIDTH  upstream beat; sampled only on push
- `ready_out`  out  1  to upstream: slice can accept a beat; registered
- `valid_out`  out  1  to downstream: beat present; registered
- `data_out`  out  DATA_WIDTH  to downstream: beat payload; registered
- `ready_in`  in  1  downstream consumer ready
- `stall_cnt`  out  STALL_CNT_WIDTH  saturating count of cycles with `valid_out && !ready_in`
- `clr_stall`  in  1  synchronous clear of `stall_cnt`

## Operation
- Handshake events:
  - push = `valid_in && ready_out`
  - pop = `valid_out && ready_in`
- Storage:
  - main register drives `data_out`.
  - skid register holds the second beat.
- States and transitions:
  - EMPTY (`valid_out`=0, `ready_out`=1):
    - push: main <= `data_in`, go to ONE.
    - otherwise: stay in EMPTY.
  - ONE (`valid_out`=1, `ready_out`=1):
    - push and pop: main <= `data_in`, stay in ONE.
    - push only: skid <= `data_in`, go to FULL.
    - pop only: go to EMPTY.
    - neither: hold.
  - FULL (`valid_out`=1, `ready_out`=0):
    - pop: main <= skid, go to ONE.
    - no pop: hold.
    - push cannot occur in FULL.
- Outputs are decoded from registered state only. There is no combinational path from `valid_in` or `ready_in` to any output.
- Ordering: beats leave in exactly the order accepted. No beat is lost or duplicated.
- Downstream guarantee: once `valid_out` rises, it and `data_out` stay stable until the cycle of pop.
- Upstream: `valid_in` may drop without a push. `data_in` is ignored when there is no push.
- Stall counter:
  - Increments by 1 each cycle with `valid_out && !ready_in`.
  - Saturates at all-ones; no wrap.
  - `clr_stall` has priority over increment: the cycle with `clr_stall`=1 loads 0.
- Skid and main contents are don't-care when their slot is empty. Reset still clears them to 0.

## Timing
- Reset values (asynchronous, while `rst`=0): state EMPTY, `ready_out`=1, `valid_out`=0, `data_out`=0, skid=0, `stall_cnt`=0.
- Reset mid-operation discards all buffered beats immediately. Outputs return to reset values without waiting for a clock.
- Latency: a beat pushed at edge N is visible on `data_out` with `valid_out`=1 after edge N. Minimum latency is 1 cycle.
- Throughput: 1 beat/cycle while `ready_in`=1.
- `ready_out` deasserts the cycle after the second unpopped beat is accepted.
- `ready_out` reasserts the cycle after the pop out of FULL.
- Simultaneous push and pop in ONE: throughput is preserved and no bubble is inserted.
- Pop in FULL: `ready_in` in the same cycle has no effect on the upstream side until the next edge.

## Test plan
- Streaming: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `ready_in`=1.
  - `data_out` shows 0x11..0x44 on consecutive cycles starting 1 cycle after the first push.
  - `ready_out` stays 1; `stall_cnt`=0.
- Back-pressure fill: `ready_in`=0, push 0xA0 then 0xA1.
  - `valid_out`=1 with `data_out`=0xA0 throughout.
  - `ready_out`=0 after the second push.
  - Raise `ready_in`: sees 0xA0 then 0xA1, then `valid_out`=0.
- Stall counter: hold `ready_in`=0 for 5 cycles with a beat present.
  - `stall_cnt`=5.
  - Assert `clr_stall` with stall ongoing: count reads 0 the next cycle, then resumes counting.
  - With `STALL_CNT_WIDTH`=4, 20 stalled cycles: `stall_cnt`=15.
- Random `ready_in` toggling (50%) with random `valid_in` over 1000 beats:
  - Scoreboard: in-order, no loss, no duplication.
  - `data_out` stable while `valid_out && !ready_in`.
- Reset mid-operation: in FULL holding 0x5 and 0x6, pulse `rst` low between edges.
  - Immediately `valid_out`=0, `ready_out`=1, `data_out`=0.
  - The next push of 0x7 is the first beat output.
- Idle `valid_in` glitch: `valid_in` high for 1 cycle while in FULL.
  - No beat is captured; output sequence is unchanged.
